// File: rtl/lcd_win_ctrl.sv
// lcd_win_ctrl: display window controller.
// Loads an IMG_W x IMG_H frame from a raster pixel stream and then streams out a
// WIN x WIN window at a movable, saturating origin. Each accepted command holds busy
// high until the window has been output and one idle cycle has followed.
// Optional feature macro: LCD_WIN_MIRROR_EN adds cmd 6 (H-mirror toggle) and
// cmd 7 (V-flip toggle). Without the macro, cmds 6 and 7 are ignored.
module lcd_win_ctrl #(
    parameter int unsigned DW    = 8,
    parameter int unsigned IMG_W = 6,
    parameter int unsigned IMG_H = 6,
    parameter int unsigned WIN   = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] datain,
    input  logic [2:0]    cmd,
    input  logic          cmd_valid,
    output logic [DW-1:0] dataout,
    output logic          output_valid,
    output logic          busy
);

    localparam int unsigned NPIX = IMG_W * IMG_H;
    localparam int unsigned AW   = $clog2(NPIX) + 1;
    localparam int unsigned AIW  = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int unsigned XW   = $clog2(IMG_W) + 1;
    localparam int unsigned YW   = $clog2(IMG_H) + 1;
    localparam int unsigned WW   = $clog2(WIN) + 1;

    localparam logic [XW-1:0] OX0    = XW'((IMG_W - WIN + 1) / 2);
    localparam logic [YW-1:0] OY0    = YW'((IMG_H - WIN + 1) / 2);
    localparam logic [XW-1:0] OX_MAX = XW'(IMG_W - WIN);
    localparam logic [YW-1:0] OY_MAX = YW'(IMG_H - WIN);
    localparam logic [WW-1:0] W_LAST = WW'(WIN - 1);
    localparam logic [AW-1:0] N_LAST = AW'(NPIX - 1);

    localparam logic [2:0] CmdRefresh = 3'd0;
    localparam logic [2:0] CmdLoad    = 3'd1;
    localparam logic [2:0] CmdRight   = 3'd2;
    localparam logic [2:0] CmdLeft    = 3'd3;
    localparam logic [2:0] CmdUp      = 3'd4;
    localparam logic [2:0] CmdDown    = 3'd5;

    typedef enum logic [1:0] {StIdle, StLoad, StOut, StDone} state_e;

    state_e state_q, state_d;

    logic [DW-1:0] mem_q [NPIX];
    logic [AW-1:0] ld_cnt_q;
    logic [WW-1:0] r_q, c_q;
    logic [XW-1:0] ox_q;
    logic [YW-1:0] oy_q;
    logic [DW-1:0] dataout_q;
    logic          valid_q;

    logic          cmd_legal;
    logic          accept;
    logic          load_last;
    logic          out_last;
    logic [WW-1:0] r_eff, c_eff;
    logic [AIW-1:0] pix_addr;

`ifdef LCD_WIN_MIRROR_EN
    localparam logic [2:0] CmdHMir = 3'd6;
    localparam logic [2:0] CmdVFlp = 3'd7;
    logic hmir_q, vflip_q;

    assign cmd_legal = 1'b1;
    assign c_eff     = hmir_q  ? (W_LAST - c_q) : c_q;
    assign r_eff     = vflip_q ? (W_LAST - r_q) : r_q;
`else
    assign cmd_legal = (cmd <= CmdDown);
    assign c_eff     = c_q;
    assign r_eff     = r_q;
`endif

    assign accept    = cmd_valid && (state_q == StIdle) && cmd_legal;
    assign load_last = (ld_cnt_q == N_LAST);
    assign out_last  = (r_q == W_LAST) && (c_q == W_LAST);
    // Origin saturation keeps row/col within the frame, so no wrap is possible.
    assign pix_addr  = (AIW'(oy_q) + AIW'(r_eff)) * AIW'(IMG_W) + AIW'(ox_q) + AIW'(c_eff);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> (LOAD) -> OUT -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = (cmd == CmdLoad) ? StLoad : StOut;
            StLoad: if (load_last) state_d = StOut;
            StOut:  if (out_last) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs: busy covers every non-idle state, pixel stream is registered.
    always_comb begin
        busy         = (state_q != StIdle);
        dataout      = dataout_q;
        output_valid = valid_q;
    end

    // Datapath: frame buffer, origin, counters and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NPIX; i++) mem_q[i] <= '0;
            ld_cnt_q  <= '0;
            r_q       <= '0;
            c_q       <= '0;
            ox_q      <= OX0;
            oy_q      <= OY0;
            dataout_q <= '0;
            valid_q   <= 1'b0;
`ifdef LCD_WIN_MIRROR_EN
            hmir_q    <= 1'b0;
            vflip_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        ld_cnt_q <= '0;
                        r_q      <= '0;
                        c_q      <= '0;
                        case (cmd)
                            CmdLoad: begin
                                ox_q <= OX0;
                                oy_q <= OY0;
`ifdef LCD_WIN_MIRROR_EN
                                hmir_q  <= 1'b0;
                                vflip_q <= 1'b0;
`endif
                            end
                            CmdRight: if (ox_q < OX_MAX) ox_q <= ox_q + 1'b1;
                            CmdLeft:  if (ox_q != '0) ox_q <= ox_q - 1'b1;
                            CmdUp:    if (oy_q != '0) oy_q <= oy_q - 1'b1;
                            CmdDown:  if (oy_q < OY_MAX) oy_q <= oy_q + 1'b1;
`ifdef LCD_WIN_MIRROR_EN
                            CmdHMir:  hmir_q  <= ~hmir_q;
                            CmdVFlp:  vflip_q <= ~vflip_q;
`endif
                            default: ;
                        endcase
                    end
                end
                StLoad: begin
                    mem_q[ld_cnt_q[AIW-1:0]] <= datain;
                    ld_cnt_q <= ld_cnt_q + 1'b1;
                end
                StOut: begin
                    dataout_q <= mem_q[pix_addr];
                    valid_q   <= 1'b1;
                    if (c_q == W_LAST) begin
                        c_q <= '0;
                        r_q <= r_q + 1'b1;
                    end else begin
                        c_q <= c_q + 1'b1;
                    end
                end
                StDone: valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // Unused unless CmdRefresh is named explicitly; keeps the command map readable.
    logic unused_refresh;
    assign unused_refresh = (cmd == CmdRefresh);

endmodule

// File: tb/tb_lcd_win_ctrl.sv
// Testbench for lcd_win_ctrl: directed scenarios followed by random commands,
// checked against a frame/origin model written from the command semantics.
module tb_lcd_win_ctrl;

    localparam int DW    = 8;
    localparam int IMG_W = 6;
    localparam int IMG_H = 6;
    localparam int WIN   = 3;
    localparam int N     = IMG_W * IMG_H;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] datain = '0;
    logic [2:0]    cmd = '0;
    logic          cmd_valid = 1'b0;
    logic [DW-1:0] dataout;
    logic          output_valid;
    logic          busy;

    lcd_win_ctrl #(.DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN)) dut (
        .clk          (clk),
        .reset        (reset),
        .datain       (datain),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .dataout      (dataout),
        .output_valid (output_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int frame [N];
    int img   [N];
    int mox, moy;
    bit mh, mv;
    int last_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) frame[i] = 0;
        mox = (IMG_W - WIN + 1) / 2;
        moy = (IMG_H - WIN + 1) / 2;
        mh = 0;
        mv = 0;
        last_out = 0;
    endtask

    function automatic bit legal(input int c);
`ifdef LCD_WIN_MIRROR_EN
        return 1'b1;
`else
        return c <= 5;
`endif
    endfunction

    task automatic model_cmd(input int c);
        case (c)
            1: begin
                for (int i = 0; i < N; i++) frame[i] = img[i];
                mox = (IMG_W - WIN + 1) / 2;
                moy = (IMG_H - WIN + 1) / 2;
                mh = 0;
                mv = 0;
            end
            2: mox = (mox + 1 > IMG_W - WIN) ? IMG_W - WIN : mox + 1;
            3: mox = (mox == 0) ? 0 : mox - 1;
            4: moy = (moy == 0) ? 0 : moy - 1;
            5: moy = (moy + 1 > IMG_H - WIN) ? IMG_H - WIN : moy + 1;
            6: mh = !mh;
            7: mv = !mv;
            default: ;
        endcase
    endtask

    function automatic int exp_pix(input int p);
        int r, c;
        r = p / WIN;
        c = p % WIN;
        if (mh) c = WIN - 1 - c;
        if (mv) r = WIN - 1 - r;
        return frame[(moy + r) * IMG_W + mox + c];
    endfunction

    // Called at a negedge; returns at the negedge after busy has dropped.
    task automatic run_cmd(input int c, input int pulse_at);
        cmd = 3'(c);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (!legal(c)) begin
            check("illegal_busy", busy, 0);
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                check("illegal_valid", output_valid, 0);
                check("illegal_hold", dataout, last_out);
            end
            return;
        end
        check("accept_busy", busy, 1);
        model_cmd(c);
        if (c == 1) begin
            for (int i = 0; i < N; i++) begin
                datain = DW'(img[i]);
                @(negedge clk);
                if (i == 0 || i == N - 1) check("load_busy", busy, 1);
                check("load_novalid", output_valid, 0);
            end
            datain = DW'($urandom);
        end
        for (int p = 0; p < WIN * WIN; p++) begin
            cmd_valid = (p == pulse_at);
            cmd = 3'($urandom_range(0, 7));
            @(negedge clk);
            check($sformatf("out_valid[%0d]", p), output_valid, 1);
            check($sformatf("out_pix[%0d]", p), dataout, exp_pix(p));
            check("out_busy", busy, 1);
            last_out = exp_pix(p);
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        check("done_valid", output_valid, 0);
        check("done_busy", busy, 0);
        check("done_hold", dataout, last_out);
    endtask

    initial begin
        int c, pa;
        model_reset();
        // Reset state.
        #2;
        check("rst_dataout", dataout, 0);
        check("rst_valid", output_valid, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Load ramp, then shift right into saturation.
        for (int i = 0; i < N; i++) img[i] = i;
        run_cmd(1, -1);
        run_cmd(2, -1);
        run_cmd(2, 4);
        run_cmd(2, -1);
        // Up into saturation, refresh.
        run_cmd(3, -1);
        for (int i = 0; i < 3; i++) run_cmd(4, 2);
        run_cmd(0, 0);
        // Mirror command (feature-dependent).
        run_cmd(6, -1);
        run_cmd(7, -1);
        run_cmd(5, -1);
        run_cmd(0, -1);

        // Async reset at the 4th output of a refresh.
        cmd = 3'd0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_dataout", dataout, 0);
        check("midrst_valid", output_valid, 0);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        check("midrst_stay", output_valid, 0);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        run_cmd(0, -1);

        // Random commands.
        for (int i = 0; i < 40; i++) begin
            c = (i == 0) ? 1 : int'($urandom_range(0, 7));
            if (c == 1) for (int j = 0; j < N; j++) img[j] = int'($urandom_range(0, 255));
            pa = int'($urandom_range(0, 14));
            run_cmd(c, pa);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
